regfile_write_queue: RTL and testbench

- Buffers register writebacks from variable-latency producers (load unit, multi-cycle units) and drains them into the register file's single write port (reg_write / rd / write_data).
- Drains only in cycles when the in-order pipeline writeback is not using the port.
- Provides forwarding lookups on rs1/rs2 so decode sees values still pending in the queue.

---
 rtl/regfile_write_queue.sv | 65 ++++++
 tb/tb_regfile_write_queue.sv | 120 ++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: FIFO of late register writebacks drained into the free regfile port, with forwarding lookups
module regfile_write_queue #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enq_valid,
  input  logic [4:0]    enq_rd,
  input  logic [31:0]   enq_data,
  output logic          enq_ready,
  input  logic          port_busy,
  output logic          reg_write,
  output logic [4:0]    rd,
  output logic [31:0]   write_data,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  output logic          fwd_hit1,
  output logic [31:0]   fwd_data1,
  output logic          fwd_hit2,
  output logic [31:0]   fwd_data2,
  output logic [AW:0]   count,
  output logic          empty
);
  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head, tail;
  logic          push;
  assign empty      = count == '0;
  assign enq_ready  = count != (AW+1)'(DEPTH);
  assign push       = enq_valid && enq_ready && enq_rd != 5'd0;
  assign reg_write  = !empty && !port_busy;
  assign rd         = reg_write ? rd_q[head] : 5'd0;
  assign write_data = reg_write ? data_q[head] : 32'd0;
  // youngest valid entry matching rs wins; entries past count are stale and ignored
  function automatic logic [32:0] lookup(input logic [4:0] rs);
    logic [32:0] r;
    logic [AW-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (rs != 5'd0 && (AW+1)'(i) < count && rd_q[idx] == rs) r = {1'b1, data_q[idx]};
    end
    return r;
  endfunction
  assign {fwd_hit1, fwd_data1} = lookup(rs1);
  assign {fwd_hit2, fwd_data2} = lookup(rs2);
  // pointers and occupancy; pop happens on the same edge the regfile captures the write
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (reg_write) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(reg_write);
    end
  // entry storage needs no reset: validity comes from head/count
  always_ff @(posedge clk)
    if (push) begin
      rd_q[tail]   <= enq_rd;
      data_q[tail] <= enq_data;
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed and random stimulus checked against a queue-based reference model
module tb_regfile_write_queue;
  logic clk = 0, reset;
  logic enq_valid, enq_ready, port_busy, reg_write, fwd_hit1, fwd_hit2, empty;
  logic [4:0] enq_rd, rd, rs1, rs2;
  logic [31:0] enq_data, write_data, fwd_data1, fwd_data2;
  logic [2:0] count;
  int checks = 0, errors = 0;
  typedef struct {logic [4:0] r; logic [31:0] d;} ent_t;
  ent_t q[$];

  regfile_write_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_rd(enq_rd), .enq_data(enq_data),
    .enq_ready(enq_ready), .port_busy(port_busy), .reg_write(reg_write), .rd(rd),
    .write_data(write_data), .rs1(rs1), .rs2(rs2), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 33'd0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].r == rs) return {1'b1, q[i].d};
    return 33'd0;
  endfunction

  task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d,
                      input logic b, input logic [4:0] a1, input logic [4:0] a2);
    logic rdy, wr;
    logic [4:0] erd;
    logic [31:0] edat;
    @(negedge clk);
    enq_valid = v; enq_rd = r; enq_data = d; port_busy = b; rs1 = a1; rs2 = a2;
    #1;
    rdy = q.size() != 4;
    wr = q.size() != 0 && !b;
    erd = 5'd0;
    edat = 32'd0;
    if (wr) begin
      erd = q[0].r;
      edat = q[0].d;
    end
    chk("enq_ready", 64'(enq_ready), 64'(rdy));
    chk("reg_write", 64'(reg_write), 64'(wr));
    chk("rd", 64'(rd), 64'(erd));
    chk("write_data", 64'(write_data), 64'(edat));
    chk("fwd1", 64'({fwd_hit1, fwd_data1}), 64'(ref_fwd(a1)));
    chk("fwd2", 64'({fwd_hit2, fwd_data2}), 64'(ref_fwd(a2)));
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    @(posedge clk);
    if (wr) void'(q.pop_front());
    if (v && rdy && r != 5'd0) q.push_back('{r, d});
  endtask

  task automatic mid_reset(input logic [4:0] probe);
    @(negedge clk);
    enq_valid = 0; port_busy = 0; rs1 = probe; reset = 1;
    #1;
    chk("rst_reg_write", 64'(reg_write), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_fwd_hit1", 64'(fwd_hit1), 64'd0);
    chk("rst_write_data", 64'(write_data), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    q.delete();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1; enq_valid = 0; enq_rd = 0; enq_data = 0; port_busy = 0; rs1 = 0; rs2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    step(0, 0, 0, 0, 5'd3, 5'd0);
    // single entry held by a busy port, then drained once
    step(1, 5'd5, 32'hAAAA0001, 1, 5'd5, 5'd0);
    repeat (2) step(0, 0, 0, 1, 5'd5, 5'd0);
    step(0, 0, 0, 0, 5'd5, 5'd0);
    step(0, 0, 0, 0, 5'd5, 5'd0);
    // fill, overflow attempt, strict-order drain
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'h100 + i, 1, 5'd2, 5'd4);
    step(1, 5'd9, 32'h999, 1, 5'd9, 5'd1);
    repeat (5) step(0, 0, 0, 0, 5'd9, 5'd4);
    // duplicates: youngest value forwarded until the last copy drains
    step(1, 5'd7, 32'h11, 1, 5'd7, 5'd0);
    step(1, 5'd7, 32'h22, 1, 5'd7, 5'd0);
    repeat (3) step(0, 0, 0, 0, 5'd7, 5'd0);
    // x0 writes vanish
    step(1, 5'd0, 32'hDEAD, 0, 5'd0, 5'd0);
    step(0, 0, 0, 0, 5'd0, 5'd0);
    // steady enqueue+drain pairs walk the pointers around the ring
    step(1, 5'd1, 32'h5000, 1, 5'd1, 5'd2);
    for (int i = 0; i < 10; i++) step(1, 5'(2 + i), 32'h5001 + i, 0, 5'(1 + i), 5'(2 + i));
    step(0, 0, 0, 0, 0, 0);
    // reset while entries are pending
    step(1, 5'd3, 32'h33, 1, 0, 0);
    step(1, 5'd4, 32'h44, 1, 0, 0);
    mid_reset(5'd3);
    repeat (3) step(0, 0, 0, 0, 5'd3, 5'd4);
    // random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) mid_reset(5'($urandom_range(0, 7)));
      else step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
